// File: rtl/modsimrand_hist.sv
// Windowed histogram of PN words binned by their top BIN_BITS bits, drained over valid/ready.
// Optional chi-square accumulator enabled by defining MODSIMRAND_HIST_CHISQ_EN.
module modsimrand_hist #(
    parameter int unsigned BIN_BITS    = 4,
    parameter int unsigned WINDOW_LOG2 = 10,
    localparam int unsigned CNT_W      = WINDOW_LOG2 + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic [31:0]         din,
    output logic                bin_valid,
    input  logic                bin_ready,
    output logic [BIN_BITS-1:0] bin_idx,
    output logic [CNT_W-1:0]    bin_count,
    output logic                bin_last,
    output logic [15:0]         dropped
`ifdef MODSIMRAND_HIST_CHISQ_EN
    ,
    output logic [2*(CNT_W+1)+BIN_BITS-1:0] chisq,
    output logic                            chisq_valid
`endif
);

    localparam int unsigned NBINS = 1 << BIN_BITS;
    localparam logic [BIN_BITS-1:0] LAST_IDX = '1;

    typedef enum logic {ACCUM, DUMP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       counts [NBINS];
    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [BIN_BITS-1:0]    din_bin;
    logic [BIN_BITS-1:0]    idx_next;
    logic                   accept;
    logic                   window_close;
    logic                   din_unused;

    assign din_bin      = din[31 -: BIN_BITS];
    assign din_unused   = ^din[31-BIN_BITS:0];
    assign idx_next     = bin_idx + BIN_BITS'(1);
    assign accept       = bin_valid & bin_ready;
    assign window_close = (state == ACCUM) && clk_en && (&sample_cnt);

    // Accumulate samples, then present one bin per accepted handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            bin_valid  <= 1'b0;
            bin_idx    <= '0;
            bin_count  <= '0;
            bin_last   <= 1'b0;
            dropped    <= '0;
            for (int unsigned i = 0; i < NBINS; i++) begin
                counts[BIN_BITS'(i)] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (clk_en) begin
                        counts[din_bin] <= counts[din_bin] + CNT_W'(1);
                        sample_cnt      <= sample_cnt + WINDOW_LOG2'(1);
                        if (&sample_cnt) begin
                            state     <= DUMP;
                            bin_valid <= 1'b1;
                            bin_idx   <= '0;
                            bin_last  <= (LAST_IDX == '0);
                            // Bin 0 may be the one the closing sample lands in
                            bin_count <= (din_bin == '0) ? counts[0] + CNT_W'(1) : counts[0];
                        end
                    end
                end
                DUMP: begin
                    if (clk_en && (dropped != 16'hFFFF)) begin
                        dropped <= dropped + 16'd1;
                    end
                    if (accept) begin
                        counts[bin_idx] <= '0;
                        if (bin_last) begin
                            state     <= ACCUM;
                            bin_valid <= 1'b0;
                            bin_idx   <= '0;
                            bin_count <= '0;
                            bin_last  <= 1'b0;
                        end else begin
                            bin_idx   <= idx_next;
                            bin_count <= counts[idx_next];
                            bin_last  <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef MODSIMRAND_HIST_CHISQ_EN
    localparam int unsigned CHISQ_W = 2 * (CNT_W + 1) + BIN_BITS;
    localparam int unsigned EXP_CNT = 1 << (WINDOW_LOG2 - BIN_BITS);

    logic signed [CNT_W:0]     diff;
    logic signed [2*CNT_W+1:0] sq;

    assign diff = $signed({1'b0, bin_count}) - $signed((CNT_W+1)'(EXP_CNT));
    assign sq   = diff * diff;

    // Sum of squared deviations over the accepted bins of one dump
    always_ff @(posedge clk) begin
        if (reset) begin
            chisq       <= '0;
            chisq_valid <= 1'b0;
        end else begin
            chisq_valid <= 1'b0;
            if (window_close) begin
                chisq <= '0;
            end else if ((state == DUMP) && accept) begin
                chisq       <= chisq + CHISQ_W'($unsigned(sq));
                chisq_valid <= bin_last;
            end
        end
    end
`endif

endmodule

// File: tb/tb_modsimrand_hist.sv
// Self-checking bench for modsimrand_hist: table of window scenarios plus randomized windows vs a histogram model.
module tb_modsimrand_hist;

    localparam int NB  = 16;
    localparam int WIN = 1024;
    localparam int E   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [31:0] din;
    logic        bin_valid;
    logic        bin_ready;
    logic [3:0]  bin_idx;
    logic [10:0] bin_count;
    logic        bin_last;
    logic [15:0] dropped;
`ifdef MODSIMRAND_HIST_CHISQ_EN
    logic [27:0] chisq;
    logic        chisq_valid;
`endif

    modsimrand_hist dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .din       (din),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_idx   (bin_idx),
        .bin_count (bin_count),
        .bin_last  (bin_last),
        .dropped   (dropped)
`ifdef MODSIMRAND_HIST_CHISQ_EN
        ,
        .chisq       (chisq),
        .chisq_valid (chisq_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int     pat;        // 0 const F0000000, 1 nibble cycles, 2 random, 3 bins 0-3 only
        bit     gaps;       // random clk_en gaps while accumulating
        int     stall_max;  // random ready stalls per bin
        int     en_dump;    // 0 no clk_en in dump, 1 clk_en only while stalled, 2 random
        int     stall0;     // forced stall on bin 0
        int     abort_at;   // reset when this bin is presented, -1 none
        longint exp0;       // expected bin 0 count, -1 don't care
        longint exp15;      // expected bin 15 count
        longint exp_drop;   // expected dropped increase over the dump
        longint exp_chisq;  // expected chisq
    } vec_t;

    int     vectors     = 0;
    int     miscompares = 0;
    int     exp_dropped = 0;
    int     hist [NB];
    vec_t   tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_word(input int pat, input int n);
        logic [31:0] w;
        w = $urandom;
        case (pat)
            0:       w = 32'hF000_0000;
            1:       w[31:28] = 4'(n % 16);
            3:       w = w & 32'h3FFF_FFFF;
            default: ;
        endcase
        return w;
    endfunction

    task automatic run_window(input vec_t v);
        int     n;
        int     drop_entry;
        longint sq;
        n  = 0;
        sq = 0;
        for (int i = 0; i < NB; i++) hist[i] = 0;
        bin_ready = 1'($urandom_range(0, 1));
        while (n < WIN) begin
            chk("idle_valid", bin_valid, 0);
            clk_en = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            din    = gen_word(v.pat, n);
            if (clk_en) begin
                hist[din[31:28]]++;
                n++;
            end
            tick();
        end
        chk("entry_valid", bin_valid, 1);
        drop_entry = exp_dropped;
        for (int i = 0; i < NB; i++) begin
            int st;
            st = (i == 0 && v.stall0 > 0) ? v.stall0 : $urandom_range(0, v.stall_max);
            for (int s = 0; s <= st; s++) begin
                if (i == v.abort_at) begin
                    reset  = 1'b1;
                    clk_en = 1'b1;
                    din    = $urandom;
                    tick();
                    reset = 1'b0;
                    exp_dropped = 0;
                    chk("abort_valid", bin_valid, 0);
                    chk("abort_dropped", dropped, 0);
                    chk("abort_idx", bin_idx, 0);
                    chk("abort_count", bin_count, 0);
                    chk("abort_last", bin_last, 0);
                    return;
                end
                chk("dump_valid", bin_valid, 1);
                chk("dump_idx", bin_idx, i);
                chk("dump_count", bin_count, hist[i]);
                chk("dump_last", bin_last, (i == NB - 1));
                chk("dump_dropped", dropped, exp_dropped);
                if (s == 0 && i == 0 && v.exp0 >= 0) chk("tbl_bin0", bin_count, v.exp0);
                if (s == 0 && i == NB - 1 && v.exp15 >= 0) chk("tbl_bin15", bin_count, v.exp15);
                bin_ready = (s == st);
                case (v.en_dump)
                    0:       clk_en = 1'b0;
                    1:       clk_en = (s < st);
                    default: clk_en = 1'($urandom_range(0, 1));
                endcase
                din = $urandom;
                if (clk_en && exp_dropped < 65535) exp_dropped++;
                tick();
            end
        end
        chk("done_valid", bin_valid, 0);
        chk("done_idx", bin_idx, 0);
        chk("done_dropped", dropped, exp_dropped);
        if (v.exp_drop >= 0) chk("tbl_dropped", dropped, drop_entry + v.exp_drop);
`ifdef MODSIMRAND_HIST_CHISQ_EN
        for (int i = 0; i < NB; i++) sq += longint'((hist[i] - E) * (hist[i] - E));
        chk("chisq_pulse", chisq_valid, 1);
        chk("chisq", chisq, sq);
        if (v.exp_chisq >= 0) chk("tbl_chisq", chisq, v.exp_chisq);
        clk_en    = 1'b0;
        bin_ready = 1'b0;
        tick();
        chk("chisq_pulse_end", chisq_valid, 0);
        chk("chisq_hold", chisq, sq);
`endif
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 0, 0, 0,  -1, 0,  1024, 0,  983040};
        tbl[1] = '{1, 1'b0, 0, 0, 0,  -1, 64, 64,   0,  0};
        tbl[2] = '{0, 1'b0, 0, 1, 20, -1, 0,  1024, 20, 983040};
        tbl[3] = '{2, 1'b1, 3, 2, 0,  7,  -1, -1,   -1, -1};
        tbl[4] = '{3, 1'b1, 2, 2, 0,  -1, -1, 0,    -1, -1};
        tbl[5] = '{1, 1'b1, 1, 0, 0,  -1, 64, 64,   0,  0};
        tbl[6] = '{2, 1'b0, 0, 2, 0,  -1, -1, -1,   -1, -1};

        reset     = 1'b1;
        clk_en    = 1'b1;
        din       = 32'hFFFF_FFFF;
        bin_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", bin_valid, 0);
        chk("rst_idx", bin_idx, 0);
        chk("rst_count", bin_count, 0);
        chk("rst_last", bin_last, 0);
        chk("rst_dropped", dropped, 0);
`ifdef MODSIMRAND_HIST_CHISQ_EN
        chk("rst_chisq", chisq, 0);
        chk("rst_chisq_valid", chisq_valid, 0);
`endif
        reset = 1'b0;
        exp_dropped = 0;

        for (int k = 0; k < 7; k++) run_window(tbl[k]);

        for (int k = 0; k < 8; k++) begin
            vec_t r;
            r = '{2 + (k % 2), 1'($urandom_range(0, 1)), 3, 2, 0, -1, -1, -1, -1, -1};
            run_window(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/modsimrand_hist.md
# modsimrand_hist

Windowed histogram monitor that sits directly downstream of the lagged-Fibonacci PN word generator and consumes its 32-bit `dout` stream. It bins each sampled word by its most-significant bits over a fixed window of samples. It then drains the bin counts over a valid/ready handshake so the MATLAB co-simulation bench can check the generator's uniformity. Sampling stops while a dump is in progress.

## Interface
- `BIN_BITS`, default 4: number of top word bits used as the bin index; there are 2^BIN_BITS bins.
- `WINDOW_LOG2`, default 10: window length is 2^WINDOW_LOG2 samples.
- `CNT_W`, default WINDOW_LOG2+1: bin counter width (derived, not overridden).
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `clk_en`, input, 1: sample qualifier, the same signal that drives the generator.
- `din`, input, 32: PN word from the generator's `dout`.
- `bin_valid`, output, 1: a bin record is presented.
- `bin_ready`, input, 1: the consumer accepts the record.
- `bin_idx`, output, BIN_BITS: index of the presented bin.
- `bin_count`, output, CNT_W: count for the presented bin.
- `bin_last`, output, 1: asserted with the final bin, index 2^BIN_BITS-1.
- `dropped`, output, 16: saturating count of samples discarded during DUMP.

## Operation
- Bin index is `din[31:32-BIN_BITS]`.
- There are two states, ACCUM and DUMP.
- ACCUM:
  - On every edge with `clk_en`=1, the addressed bin counter increments and `sample_cnt` increments.
  - When the 2^WINDOW_LOG2-th sample is captured, `sample_cnt` wraps to 0 and the next state is DUMP with `bin_idx`=0.
- DUMP:
  - `bin_valid`=1, and `bin_count` is the registered count for `bin_idx`.
  - On `bin_valid & bin_ready`, the presented bin counter is cleared to 0 and `bin_idx` advances.
  - On acceptance with `bin_last`=1, the state returns to ACCUM and `bin_idx` resets to 0.
- The handshake is independent of `clk_en`. While `bin_ready`=0, `bin_idx`, `bin_count` and `bin_last` hold stable.
- `clk_en`=1 in DUMP: the sample is discarded and `dropped` increments, saturating at 0xFFFF. `dropped` is cleared only by reset.
- Counter width: one bin can receive every sample of the window, so CNT_W = WINDOW_LOG2+1 never overflows.
- Reset:
  - Takes effect on any rising edge, regardless of `clk_en`.
  - State becomes ACCUM and all bin counters, `sample_cnt`, `bin_idx` and `dropped` become 0.
  - Outputs: `bin_valid`=0, `bin_idx`=0, `bin_count`=0, `bin_last`=0, `dropped`=0.
  - Reset mid-DUMP abandons the remaining bins; no partial window is ever emitted.
- The generator holds 0xFFFFFFFF while it is in reset. The bench deasserts both resets together, so those words are never sampled.

## Timing
- The sample captured at edge N is reflected in its bin counter after edge N.
- Window close: the last sample is captured at edge N, and `bin_valid`=1 with `bin_idx`=0 is visible after edge N.
- With `bin_ready` held at 1, the dump takes exactly 2^BIN_BITS cycles, one bin per cycle.
- After the last bin is accepted at edge M, the state is ACCUM after edge M, and the first new sample can be taken at edge M+1.
- A `clk_en` sample coincident with the final acceptance edge is dropped, because the state is still DUMP at that edge.

## Configuration
- Macro: `MODSIMRAND_HIST_CHISQ_EN`.
- When defined, two extra outputs are compiled in:
  - `chisq`, 2*(CNT_W+1)+BIN_BITS bits: accumulates (count − E)^2 over the accepted bins, where E = 2^(WINDOW_LOG2−BIN_BITS).
    - The difference is signed, CNT_W+1 bits.
    - The accumulator clears at DUMP entry.
    - The final value is held until the next DUMP entry or reset.
  - `chisq_valid`, 1 bit: a one-cycle pulse on the cycle after the `bin_last` acceptance.
- Reset value of both `chisq` and `chisq_valid` is 0.
- When not defined, neither port exists and no squaring logic is synthesized.

## Test plan
- Constant `din`=0xF0000000, `clk_en`=1, `bin_ready`=1 → 16 records: bins 0–14 count 0, bin 15 count 1024, `bin_last` only on idx 15.
- `din` top nibble cycles 0..15 each sample, 1024 samples → every bin count 64; next window starts on the cycle after the idx-15 acceptance.
- `bin_ready`=0 for 20 cycles at DUMP entry with `clk_en`=1 → idx 0 held stable, `dropped`=20, no bin cleared; then release and all 16 bins drain normally.
- `reset` pulsed while `bin_idx`=7 during DUMP → next edge `bin_valid`=0, `dropped`=0; a fresh 1024-sample window is needed before the next dump.
- With `MODSIMRAND_HIST_CHISQ_EN`, constant-word stimulus → `chisq`=983040 (960²+15·64²) with a single `chisq_valid` pulse; uniform stimulus → `chisq`=0.
- Generator connected (its `dout` to `din`), 50 windows → no counter overflow, every dump yields counts summing to 1024.
